// File: rtl/opcode_dispatcher_pkg.sv
// rtl/opcode_dispatcher_pkg.sv - opcode word, dispatcher state and argument index definitions
package Opcode_p;

  localparam int ARG_BITS  = 12;
  localparam int FLAG_BITS = 4;

  typedef enum logic [3:0] {
    OP_G00 = 4'd0,
    OP_G01 = 4'd1,
    OP_G02 = 4'd2,
    OP_G03 = 4'd3
  } Opcode_t;

  typedef struct packed {
    Opcode_t               op;
    logic [ARG_BITS-1:0]   arg1;
    logic [ARG_BITS-1:0]   arg2;
    logic [ARG_BITS-1:0]   arg3;
    logic [ARG_BITS-1:0]   arg4;
    logic [FLAG_BITS-1:0]  flags;
  } Opcode_st;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    LINE_RUN = 2'd2,
    ARC_RUN  = 2'd3
  } Dispatch_state_t;

  // Argument slots of an opcode word: target X/Y, arc centre offset I/J.
  localparam int ARG_X = 1;
  localparam int ARG_Y = 2;
  localparam int ARG_I = 3;
  localparam int ARG_J = 4;

  function automatic logic [ARG_BITS-1:0] op_arg(input Opcode_st o, input int idx);
    logic [ARG_BITS-1:0] v;
    v = '0;
    if (idx == ARG_X)      v = o.arg1;
    else if (idx == ARG_Y) v = o.arg2;
    else if (idx == ARG_I) v = o.arg3;
    else if (idx == ARG_J) v = o.arg4;
    return v;
  endfunction

  function automatic logic is_line_op(input Opcode_t op);
    return (op == OP_G00) || (op == OP_G01);
  endfunction

  function automatic logic is_arc_op(input Opcode_t op);
    return (op == OP_G02) || (op == OP_G03);
  endfunction

endpackage

// File: rtl/opcode_fifo.sv
// rtl/opcode_fifo.sv - synchronous FIFO of opcode words
// Ports: clk, reset (async active-low), push/push_data write side,
//        pop/head read side (head is the oldest entry), full/empty registered flags.
module opcode_fifo
  import Opcode_p::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  Opcode_st push_data,
  input  logic     pop,
  output Opcode_st head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  Opcode_st       mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    wr_next;
  logic [AW:0]    rd_next;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees a slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      // Extra pointer MSB distinguishes full from empty when addresses match.
      empty  <= (wr_next == rd_next);
      full   <= (wr_next[AW] != rd_next[AW]) &&
                (wr_next[AW-1:0] == rd_next[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/opcode_dispatcher.sv
// rtl/opcode_dispatcher.sv - buffers parser opcodes and sequences line/arc executors
// Ports: clk, reset (async active-low); in_op/in_valid/in_ready parser input;
//        line_* and arc_* executor command/handshake; cur_x/cur_y pen position;
//        busy (work pending); err_op (unknown opcode discarded).
module opcode_dispatcher
  import Opcode_p::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  Opcode_st            in_op,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                line_start,
  output logic                line_rapid,
  output logic [ARG_BITS-1:0] line_x0,
  output logic [ARG_BITS-1:0] line_y0,
  output logic [ARG_BITS-1:0] line_x1,
  output logic [ARG_BITS-1:0] line_y1,
  input  logic                line_done,
  output logic                arc_start,
  output logic                arc_ccw,
  output logic [ARG_BITS-1:0] arc_x0,
  output logic [ARG_BITS-1:0] arc_y0,
  output logic [ARG_BITS-1:0] arc_x1,
  output logic [ARG_BITS-1:0] arc_y1,
  output logic [ARG_BITS-1:0] arc_i,
  output logic [ARG_BITS-1:0] arc_j,
  input  logic                arc_done,
  output logic [ARG_BITS-1:0] cur_x,
  output logic [ARG_BITS-1:0] cur_y,
  output logic                busy,
  output logic                err_op
);

  Dispatch_state_t state;
  Dispatch_state_t next_state;

  Opcode_st head;
  Opcode_t  op_reg;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     line_finish;
  logic     arc_finish;
  logic     unused_flags;

  assign unused_flags = ^head.flags;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = !fifo_empty || (state != IDLE);

  opcode_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_op),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    fifo_pop    = 1'b0;
    line_start  = 1'b0;
    arc_start   = 1'b0;
    err_op      = 1'b0;
    line_finish = 1'b0;
    arc_finish  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (is_line_op(op_reg)) begin
          line_start = 1'b1;
          next_state = LINE_RUN;
        end else if (is_arc_op(op_reg)) begin
          arc_start  = 1'b1;
          next_state = ARC_RUN;
        end else begin
          err_op     = 1'b1;
          next_state = IDLE;
        end
      end
      LINE_RUN: begin
        if (line_done) begin
          line_finish = 1'b1;
          next_state  = IDLE;
        end
      end
      ARC_RUN: begin
        if (arc_done) begin
          arc_finish = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured together with op_reg on the pop edge so they are
  // already stable during DECODE, when the start pulse is issued. Only the
  // executor the popped opcode targets has its operands reloaded; the other
  // keeps its previous command. The start point comes from cur_*, which is
  // stable in IDLE because it only changes on the done edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= OP_G00;
      line_rapid <= 1'b0;
      line_x0    <= '0;
      line_y0    <= '0;
      line_x1    <= '0;
      line_y1    <= '0;
      arc_ccw    <= 1'b0;
      arc_x0     <= '0;
      arc_y0     <= '0;
      arc_x1     <= '0;
      arc_y1     <= '0;
      arc_i      <= '0;
      arc_j      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
    end else begin
      if (fifo_pop) begin
        op_reg <= head.op;
        if (is_line_op(head.op)) begin
          line_rapid <= (head.op == OP_G00);
          line_x0    <= cur_x;
          line_y0    <= cur_y;
          line_x1    <= op_arg(head, ARG_X);
          line_y1    <= op_arg(head, ARG_Y);
        end
        if (is_arc_op(head.op)) begin
          arc_ccw <= (head.op == OP_G03);
          arc_x0  <= cur_x;
          arc_y0  <= cur_y;
          arc_x1  <= op_arg(head, ARG_X);
          arc_y1  <= op_arg(head, ARG_Y);
          arc_i   <= op_arg(head, ARG_I);
          arc_j   <= op_arg(head, ARG_J);
        end
      end
      if (line_finish) begin
        cur_x <= line_x1;
        cur_y <= line_y1;
      end else if (arc_finish) begin
        cur_x <= arc_x1;
        cur_y <= arc_y1;
      end
    end
  end

endmodule

// File: doc/opcode_dispatcher.md
# opcode_dispatcher

Sequencer between the G-code parser and the motion executors. Buffers incoming `Opcode_st` words in a small FIFO and decodes each one. It issues G00/G01 to the line executor and G02/G03 to the arc executor, one motion at a time. It holds the current pen position, so each executor receives both start and end points.

## Interface
Parameters
- `FIFO_DEPTH`, 4: opcode buffer entries; power of two, ≥2.

Ports
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_op`  in  `Opcode_st`  opcode from the parser.
- `in_valid`  in  1  `in_op` is valid.
- `in_ready`  out  1  FIFO not full; a transfer happens when `in_valid && in_ready`.
- `line_start`  out  1  one-cycle pulse that starts the line executor.
- `line_rapid`  out  1  1 = G00, 0 = G01; held while the line executor is busy.
- `line_x0`, `line_y0`, `line_x1`, `line_y1`  out  `ARG_BITS` each  line start and end points; held until done.
- `line_done`  in  1  one-cycle pulse: line complete.
- `arc_start`  out  1  one-cycle pulse that starts the arc executor.
- `arc_ccw`  out  1  1 = G03, 0 = G02.
- `arc_x0`, `arc_y0`, `arc_x1`, `arc_y1`, `arc_i`, `arc_j`  out  `ARG_BITS` each  start, end and centre offset; held until done.
- `arc_done`  in  1  one-cycle pulse: arc complete.
- `cur_x`, `cur_y`  out  `ARG_BITS` each  current pen position.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.
- `err_op`  out  1  one-cycle pulse: unknown opcode was discarded.

## Operation
- Argument mapping: `arg1`/`arg2` = target X/Y (absolute, unsigned). For arcs, `arg3`/`arg4` = I/J (two's complement), passed through unchanged. `flags` is ignored.
- FIFO: synchronous, `FIFO_DEPTH` entries. Pointers are one bit wider than the address and wrap naturally.
- A push and a pop in the same cycle are both allowed when full; `in_ready` follows the registered full flag.
- FSM states: IDLE, DECODE, LINE_RUN, ARC_RUN.
- IDLE, FIFO non-empty: pop the head into `op_reg`; go to DECODE.
- DECODE, op is `OP_G00`/`OP_G01`: load the line outputs (x0,y0 = cur; x1,y1 = arg1,arg2); pulse `line_start`; go to LINE_RUN.
- DECODE, op is `OP_G02`/`OP_G03`: load the arc outputs the same way, plus i,j; pulse `arc_start`; go to ARC_RUN.
- DECODE, any other op: pulse `err_op`; go to IDLE. Position is unchanged.
- LINE_RUN: on `line_done`, set `cur_x/cur_y` to x1/y1 and go to IDLE. `arc_done` is ignored here.
- ARC_RUN: mirror image of LINE_RUN, using `arc_done`. `line_done` is ignored here.
- Only one executor is active at any time.
- Reset values: FIFO empty, state IDLE, `in_ready`=1. All pulses and `line_rapid`/`arc_ccw` = 0. All coordinate outputs and `cur_x`/`cur_y` = 0. `busy`=0.
- Reset mid-motion drops the FIFO contents and the motion in progress. Each executor resets itself on the same `reset`.

## Timing
- Opcode accepted at edge t into an empty FIFO in IDLE:
  - edge t+1: popped into `op_reg`;
  - cycle t+2 (DECODE): `*_start` is high and the operands are valid;
  - edge t+2: state moves to RUN.
- `*_done` sampled at edge d: `cur_*` updated at d and state back in IDLE. The next pop is at d+1 if the FIFO is non-empty.
- Back-to-back throughput is therefore done-to-start = 2 cycles.
- `*_start` and `err_op` are exactly one cycle wide.
- `*_done` arriving in the same cycle as `*_start` is not legal for executors.
- `in_ready` is decoupled from the executor: the parser can fill up to `FIFO_DEPTH` entries while a motion runs.
- `busy` is combinational from the registered state and the empty flag.

## Structure
- Add `OP_G00..G03` to package `Opcode_p`; the enum is already there and is reused as is.
- Add to `Opcode_p`: a `Dispatch_state_t` enum, and `ARG_X`/`ARG_Y`/`ARG_I`/`ARG_J` index constants. No new package.
- Sub-module `opcode_fifo`: parameterised on `FIFO_DEPTH`, storing `Opcode_st`. Ports: push, pop, full, empty, head data. It is reusable by the UART parser path.
- The dispatcher holds the FSM, the operand registers and the position registers.

## Test plan
- Reset, then G01 (100,200): `line_start` fires at t+2 with x0=0, y0=0, x1=100, y1=200, `line_rapid`=0. After `line_done`, `cur`=(100,200) and `busy`=0.
- G00 (50,60) then G02 end (10,10), I=-5, J=3: line first. `arc_start` fires 2 cycles after `line_done`, with x0=50, y0=60, `arc_ccw`=0, i=0xFFB, j=3.
- Push 5 opcodes with no `done` returned, DEPTH=4: one sits in `op_reg`/RUN and 4 fill the FIFO. `in_ready`=0 on the 6th attempt, and nothing is lost.
- Opcode 7 (unknown) between two G01s: `err_op` pulses once, there is no start, and the second G01 uses the first G01's endpoint as x0/y0.
- Stray `arc_done` during LINE_RUN: ignored, state and `cur` unchanged.
- `reset` low during ARC_RUN with 3 queued: all outputs return to reset values and the FIFO is empty. The next opcode after release starts from (0,0).
